// File: rtl/bias_add_bank.sv
// Per-lane signed bias add with saturation; bias set selected by an
// auto-advancing output-channel group counter, one-deep registered output.
module bias_add_bank #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DATA_W       = 18,
  parameter int unsigned N_GROUPS     = 4,
  parameter int unsigned GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  parameter int unsigned LANE_W       = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [GRP_W-1:0]               cfg_group,
  input  logic [LANE_W-1:0]              cfg_lane,
  input  logic [DATA_W-1:0]              cfg_data,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic [GRP_W-1:0]               out_group,
  output logic                           out_last
);

  localparam int unsigned BUS_W = N_adder_tree * DATA_W;
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(N_GROUPS - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] bias [N_GROUPS][N_adder_tree];
  logic [GRP_W-1:0]  grp;
  logic [GRP_W-1:0]  grp_next;
  logic              out_valid_next;
  logic              accept;
  logic              cfg_hit;
  logic [DATA_W:0]   lane_sum;
  logic [BUS_W-1:0]  sum_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cfg_hit  = cfg_we && (32'(cfg_group) < N_GROUPS) && (32'(cfg_lane) < N_adder_tree);

  // Bias table; a same-cycle write is seen by the following beat only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < int'(N_GROUPS); g++) begin
        for (int l = 0; l < int'(N_adder_tree); l++) begin
          bias[g][l] <= '0;
        end
      end
    end else if (cfg_hit) begin
      bias[cfg_group][cfg_lane] <= cfg_data;
    end
  end

  // Sign-extended add; overflow shows as disagreement of the top two sum bits.
  always_comb begin
    sum_data = '0;
    lane_sum = '0;
    for (int i = 0; i < int'(N_adder_tree); i++) begin
      lane_sum = {in_data[i*DATA_W + DATA_W - 1], in_data[i*DATA_W +: DATA_W]}
               + {bias[grp][i][DATA_W-1], bias[grp][i]};
      if (lane_sum[DATA_W] != lane_sum[DATA_W-1]) begin
        sum_data[i*DATA_W +: DATA_W] = lane_sum[DATA_W] ? SAT_MIN : SAT_MAX;
      end else begin
        sum_data[i*DATA_W +: DATA_W] = lane_sum[DATA_W-1:0];
      end
    end
  end

  // Next-state for group sequencing and output occupancy; start beats increment.
  always_comb begin
    grp_next       = grp;
    out_valid_next = out_valid;
    if (start) begin
      grp_next = '0;
    end else if (accept) begin
      grp_next = (grp == LAST_GRP) ? '0 : GRP_W'(grp + 1'b1);
    end
    if (accept) begin
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_group <= '0;
      out_last  <= 1'b0;
    end else begin
      grp       <= grp_next;
      out_valid <= out_valid_next;
      if (accept) begin
        out_data  <= sum_data;
        out_group <= grp;
        out_last  <= (grp == LAST_GRP);
      end
    end
  end

endmodule

// File: tb/tb_bias_add_bank.sv
// Randomized and directed bench for bias_add_bank against an integer-arithmetic
// model of the bias table, group counter and one-deep output stage.
module tb_bias_add_bank;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int NG = 4;
  localparam int BW = N * DW;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_group;
  logic [3:0]    cfg_lane;
  logic [DW-1:0] cfg_data;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [1:0]    out_group;
  logic          out_last;

  bias_add_bank dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_group(cfg_group),
    .cfg_lane(cfg_lane), .cfg_data(cfg_data), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_group(out_group), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int            m_bias [NG][N];
  int            m_grp;
  bit            m_valid;
  logic [BW-1:0] m_data;
  int            m_ogrp;
  bit            m_last;

  int wrap_exp [5];
  int wrap_grp [5];
  logic [BW-1:0] saved;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] sat_add(input int a, input int b);
    int s;
    s = a + b;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return DW'(s);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ogrp  = 0;
    m_last  = 1'b0;
    m_grp   = 0;
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < N; l++) m_bias[g][l] = 0;
  endtask

  task automatic idle();
    cfg_we   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       in_data[i*DW +: DW] = 18'h1FF00 | DW'($urandom_range(0, 255));
        1:       in_data[i*DW +: DW] = 18'h20000 | DW'($urandom_range(0, 255));
        default: in_data[i*DW +: DW] = DW'($urandom);
      endcase
    end
  endtask

  // Entered just after a falling edge with inputs set; checks the outputs of
  // the previous rising edge, advances the model across the next one.
  task automatic tick();
    bit acc;
    #1;
    check("out_valid", BW'(out_valid), BW'(m_valid));
    check("in_ready", BW'(in_ready), BW'(!m_valid || out_ready));
    check("out_data", out_data, m_data);
    check("out_group", BW'(out_group), BW'(m_ogrp));
    check("out_last", BW'(out_last), BW'(m_last));
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      for (int i = 0; i < N; i++)
        m_data[i*DW +: DW] = sat_add(sx(in_data[i*DW +: DW]), m_bias[m_grp][i]);
      m_ogrp  = m_grp;
      m_last  = (m_grp == NG - 1);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (start) m_grp = 0;
    else if (acc) m_grp = (m_grp + 1) % NG;
    if (cfg_we && int'(cfg_group) < NG && int'(cfg_lane) < N)
      m_bias[cfg_group][cfg_lane] = sx(cfg_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int g, input int l, input logic [DW-1:0] d);
    idle();
    cfg_we    = 1'b1;
    cfg_group = 2'(g);
    cfg_lane  = 4'(l);
    cfg_data  = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cfg_group = '0; cfg_lane = '0; cfg_data = '0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    wrap_exp = '{11, 12, 13, 14, 11};
    wrap_grp = '{0, 1, 2, 3, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pass-through with zero biases
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 18'h00100;
    in_valid = 1'b1;
    tick();
    idle();
    check("pt_lane0", BW'(out_data[DW-1:0]), BW'(18'h00100));
    check("pt_lane15", BW'(out_data[BW-1 -: DW]), BW'(18'h00100));
    check("pt_group", BW'(out_group), BW'(0));
    check("pt_last", BW'(out_last), BW'(0));
    tick();

    // Bias per group and wrap
    for (int g = 0; g < NG; g++) cfg_write(g, 0, DW'(g + 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      in_data[DW-1:0] = 18'd10;
      in_valid = 1'b1;
      tick();
      check("wrap_lane0", BW'(out_data[DW-1:0]), BW'(wrap_exp[k]));
      check("wrap_group", BW'(out_group), BW'(wrap_grp[k]));
      check("wrap_last", BW'(out_last), BW'(k == 3));
    end
    idle();
    tick();

    // Saturation (group is now 1)
    cfg_write(1, 0, 18'h00020);
    cfg_write(1, 1, 18'h3FFE0);
    cfg_write(1, 2, 18'h00001);
    in_data = '0;
    in_data[0*DW +: DW] = 18'h1FFF0;
    in_data[1*DW +: DW] = 18'h20010;
    in_data[2*DW +: DW] = 18'h3FFFF;
    in_valid = 1'b1;
    tick();
    idle();
    check("sat_pos", BW'(out_data[0*DW +: DW]), BW'(18'h1FFFF));
    check("sat_neg", BW'(out_data[1*DW +: DW]), BW'(18'h20000));
    check("sat_mix", BW'(out_data[2*DW +: DW]), BW'(18'h00000));
    tick();

    // Backpressure: stall with valid held, then drain
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      in_valid = 1'b1;
      tick();
      check("bp_in_ready", BW'(in_ready), BW'(0));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      tick();
    end
    idle();
    tick();

    // Start + accept + config write in the same cycle at group 2
    cfg_write(2, 0, 18'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_data = '0;
    in_valid = 1'b1;
    tick();
    tick();
    start     = 1'b1;
    cfg_we    = 1'b1;
    cfg_group = 2'd2;
    cfg_lane  = 4'd0;
    cfg_data  = 18'd7;
    in_data[DW-1:0] = 18'd100;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    check("col_lane0", BW'(out_data[DW-1:0]), BW'(103));
    check("col_group", BW'(out_group), BW'(2));
    tick();
    check("col_next_group", BW'(out_group), BW'(0));
    check("col_next_lane0", BW'(out_data[DW-1:0]), BW'(101));
    idle();
    tick();

    // Asynchronous reset while an output beat is held
    out_ready = 1'b0;
    rand_data();
    in_valid = 1'b1;
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", BW'(out_valid), BW'(0));
    check("arst_data", out_data, '0);
    check("arst_group", BW'(out_group), BW'(0));
    check("arst_last", BW'(out_last), BW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    rand_data();
    saved = in_data;
    in_valid = 1'b1;
    tick();
    idle();
    for (int i = 0; i < N; i++)
      check("arst_bias_zero", BW'(out_data[i*DW +: DW]), BW'(saved[i*DW +: DW]));
    tick();

    // Randomized traffic with config writes and start pulses
    for (int k = 0; k < 1500; k++) begin
      rand_data();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 19) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_group = 2'($urandom_range(0, 3));
      cfg_lane  = 4'($urandom_range(0, 15));
      cfg_data  = DW'($urandom);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_add_bank.md
# bias_add_bank

Programmable per-lane bias-add stage for the convolution datapath. It sits between the adder-tree outputs of a layer and the activation/requantisation stage. It holds `N_GROUPS` sets of `N_adder_tree` signed biases, loaded at run time through a config port. Each accepted input beat receives the bias set of the current output-channel group, with signed saturation, and the group index advances automatically per beat.

## Interface
- `N_adder_tree`, 16, number of parallel lanes per beat
- `DATA_W`, 18, signed two's-complement width of data and bias
- `N_GROUPS`, 4, bias sets (output-channel groups) per layer; ≥1
- `GRP_W`, `$clog2(N_GROUPS)` (min 1), width of group indices
- `LANE_W`, `$clog2(N_adder_tree)` (min 1), width of lane index
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: bias write strobe
- `cfg_group` in `GRP_W`: group index of the write
- `cfg_lane` in `LANE_W`: lane index of the write
- `cfg_data` in `DATA_W`: signed bias value
- `start` in 1: synchronous pulse that restarts group sequencing at 0
- `in_valid` in 1: input beat valid
- `in_ready` out 1: block can accept a beat
- `in_data` in `N_adder_tree*DATA_W`: lane i at `[DATA_W*(i+1)-1 : DATA_W*i]`
- `out_valid` out 1: output beat valid
- `out_ready` in 1: downstream accepts
- `out_data` out `N_adder_tree*DATA_W`: biased, saturated lanes, same packing
- `out_group` out `GRP_W`: group used for this output beat
- `out_last` out 1: high when `out_group == N_GROUPS-1`

## Operation
- **Bias storage:** `N_GROUPS*N_adder_tree` registers of `DATA_W` bits. All registers are 0 at reset.
  - On `cfg_we`, entry [`cfg_group`][`cfg_lane`] takes `cfg_data` at the clock edge.
  - Out-of-range `cfg_group` or `cfg_lane` is ignored (no write).
- **Group counter `grp`:** reset value 0.
  - Increments on every accepted beat (`in_valid && in_ready`).
  - Wraps from `N_GROUPS-1` to 0.
- **Start pulse:**
  - `start` forces `grp` to 0 at the next edge.
  - If `start` and an accept occur in the same cycle, the beat uses the pre-edge `grp`, and `grp` becomes 0 (start wins over increment).
- **Arithmetic, per lane i:**
  - `sum = sext(in_i) + sext(bias[grp][i])`, computed at `DATA_W+1` bits.
  - If sum > 2^(DATA_W-1)-1, clamp to `0x1FFFF`.
  - If sum < -2^(DATA_W-1), clamp to `0x20000`.
  - Otherwise the result is `sum[DATA_W-1:0]`.
  - Values above are for `DATA_W`=18.
- **Config write vs. accept, same cycle:** the accepted beat uses the old bias value; the new value applies from the next beat.
- **Output register:**
  - `out_data`, `out_group` and `out_last` are registered and load only on accept.
  - They hold stable while `out_valid && !out_ready`.

## Timing
- **Latency:** 1 cycle. A beat accepted at edge k is presented with `out_valid`=1 after edge k.
- **Handshake:** `in_ready = !out_valid || out_ready` (combinational).
  - Full throughput: one beat per cycle while `out_ready`=1.
  - No beat is ever dropped or duplicated.
- **out_valid next state:**
  - Set on accept.
  - Cleared when `out_ready` is high and there is no accept.
  - Stays high on simultaneous drain and accept.
- **Reset values** (asynchronous assertion, synchronous release on `clk`): `out_valid`=0, `out_data`=0, `out_group`=0, `out_last`=0, `grp`=0, all biases 0.
- **Reset mid-operation:** the in-flight output beat is discarded, and loaded biases are lost. Software must reload them.
- `cfg_we` is independent of the handshake and accepted every cycle, including while stalled.

## Test plan
- **Reset then pass-through:**
  - Stimulus: release `rst_n`, send one beat with all lanes = `0x00100`, `out_ready`=1.
  - Required: after 1 cycle, all lanes = `0x00100`, `out_group`=0, `out_last`=0.
- **Bias and group wrap** (`N_GROUPS`=4):
  - Stimulus: load lane 0 biases 1, 2, 3, 4 for groups 0–3; stream 5 beats with lane 0 = 10.
  - Required: lane 0 outputs 11, 12, 13, 14, 11; `out_group` 0, 1, 2, 3, 0; `out_last` high only on the 4th beat.
- **Saturation:**
  - Positive: in = `0x1FFF0`, bias = `0x00020` → `0x1FFFF`.
  - Negative: in = `0x20010`, bias = `0x3FFE0` (-32) → `0x20000`.
  - Mixed-sign: in = `0x3FFFF` (-1), bias 1 → 0.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: `in_ready`=0 after the first accept, `out_data` stable throughout; after release, the beats drain in order with no loss and `grp` advanced exactly once per beat.
- **Start and config collisions:**
  - Stimulus: with `grp`=2, assert `start`, an accept, and `cfg_we` to [2][0] (new value 7, old value 3) in the same cycle.
  - Required: that beat uses bias 3 and `out_group`=2; the next beat uses group 0.
- **Async reset mid-stream:**
  - Stimulus: assert `rst_n` low while `out_valid`=1.
  - Required: `out_valid`, `out_data`, `out_group` and `out_last` go to 0 immediately, without waiting for a clock edge; after release, all biases read as 0 on the next beat.
